input_debouncer: RTL and testbench
==================================

# input_debouncer

Synchronises and debounces a raw, asynchronous single-bit input (push-button or switch) so downstream logic receives a clean level. Typical downstream consumer: the `notGate` inverter stage. Provides a two-flop synchroniser, a four-state stability FSM with a saturating counter, and optional one-cycle edge pulses.

## Interface
Parameters:
- `STABLE`, default 10: consecutive cycles the synchronised input must hold a new level before `o` follows it. Legal range 2..2^CNT_W.
- `CNT_W`, default 4: counter width. Must satisfy STABLE-1 <= 2^CNT_W - 1.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i` input 1: raw asynchronous input level.
- `o` output 1: debounced level, registered.
- `rise` output 1: one-cycle pulse when `o` goes 0->1, registered.
- `fall` output 1: one-cycle pulse when `o` goes 1->0, registered.
- `busy` output 1: high while a level change is being qualified (FSM in a WAIT state).

## Operation
- Synchroniser: `s1 <= i`, `s <= s1`. Only `s` feeds the FSM.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. Counter `cnt` is CNT_W bits.
- LOW: `s==1` -> WAIT_HIGH, `cnt<=1`. Otherwise stay, `cnt<=0`.
- WAIT_HIGH: `s==0` -> LOW, `cnt<=0` (glitch rejected, no pulse). `s==1` and `cnt==STABLE-1` -> HIGH, `o<=1`, `rise<=1`. Otherwise `cnt<=cnt+1`.
- HIGH and WAIT_LOW mirror LOW and WAIT_HIGH with levels inverted. WAIT_LOW -> LOW sets `o<=0` and `fall<=1`.
- `rise` and `fall` are high for exactly one cycle. They are cleared on every edge where they are not set. They are never high together.
- `busy` = state is WAIT_HIGH or WAIT_LOW. It is registered alongside the state.
- `cnt` never exceeds STABLE-1, so there is no wrap-around.
- Reset, asserted at any time including mid-WAIT: immediately forces `s1=0`, `s=0`, state=LOW, `cnt=0`, `o=0`, `rise=0`, `fall=0`, `busy=0`. No pulse is emitted on reset entry or exit.
- After reset deasserts with `i` already high, `o` rises by normal qualification and a `rise` pulse is produced.

## Timing
- Reset values: `o=0`, `rise=0`, `fall=0`, `busy=0`.
- Edge 0 is the first rising edge that samples a new level on `i`, with `i` held steady afterwards.
- `s` reflects the new level after edge 1.
- The FSM enters WAIT and `busy` goes high at edge 2.
- `o` and the pulse update at edge STABLE+1. `busy` goes low on the same edge.
- Total latency from edge 0 to the `o` change: STABLE+1 edges. With STABLE=10, `o` changes on edge 11.
- Rejection: if `s` returns to the old level on any edge while in WAIT, the change is discarded. `o` does not move, and `busy` drops on that edge.
- Any pulse on `i` that is stable for fewer than STABLE sampled cycles never reaches `o`.
- Async reset clears outputs without waiting for a clock edge.

## Configuration
- Macro `DEBOUNCE_EDGE_PULSE_EN`.
- Defined: `rise` and `fall` are generated as described in Operation.
- Undefined: the pulse registers are not built, and `rise` and `fall` are tied to constant 0. `o`, `busy`, FSM behaviour and latency are identical in both builds.

## Test plan
All scenarios use STABLE=10, CNT_W=4, clock period 10 time units.
- Reset then idle: assert `rst` for 3 cycles, `i=0` for 20 cycles -> `o=0`, `busy=0`, `rise=fall=0` throughout.
- Clean rise: `i` 0->1 before edge 0 and held -> `busy=1` from edge 2, then `o=1`, `rise=1`, `busy=0` on edge 11. `rise=0` on edge 12.
- Glitch reject: `i` high for 5 cycles, then back to 0 -> `o` stays 0, `rise` never asserts, `busy` returns to 0 within 3 cycles of `i` falling.
- Clean fall: from `o=1`, `i` 1->0 and held -> `o=0` and `fall=1` on edge 11, then `fall=0` on edge 12.
- Reset mid-qualification: `i`=1, assert `rst` asynchronously at edge 6 mid-cycle -> `o`, `busy` and `cnt` are 0 immediately. After release with `i` still 1, `o` rises 11 edges after the first post-reset edge.
- Macro off: repeat the clean-rise and clean-fall scenarios without `DEBOUNCE_EDGE_PULSE_EN` -> same `o` timing, and `rise=fall=0` always.

Source files
------------

// File: rtl/input_debouncer_if.sv
// Level/pulse bundle between a raw input source and the debouncer.
// master drives the raw level; slave returns the clean level, edge pulses and busy.
interface input_debouncer_if;
    logic i;
    logic o;
    logic rise;
    logic fall;
    logic busy;

    // i is a free-running asynchronous level, no handshake. o/busy are levels;
    // rise/fall are single-cycle strobes, each valid only on the cycle it is high.
    modport master (output i, input o, input rise, input fall, input busy);
    modport slave  (input i, output o, output rise, output fall, output busy);
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus four-state stability FSM that debounces a raw input.
// Macro DEBOUNCE_EDGE_PULSE_EN builds the rise/fall pulse registers; otherwise both are tied to 0.
module input_debouncer #(
    parameter int STABLE = 10,
    parameter int CNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input_debouncer_if.slave   bus,
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             o_q;
    logic             busy_q;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic             rise_q;
    logic             fall_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            s1 <= bus.i;
            s  <= s1;
        end
    end

    // cnt counts qualifying cycles already seen; the transition fires when it reaches STABLE-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOW;
            cnt    <= '0;
            o_q    <= 1'b0;
            busy_q <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`endif
        end else begin
`ifdef DEBOUNCE_EDGE_PULSE_EN
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`endif
            case (state)
                LOW: begin
                    if (s) begin
                        state  <= WAIT_HIGH;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s) begin
                        state  <= LOW;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= HIGH;
                        cnt    <= '0;
                        o_q    <= 1'b1;
                        busy_q <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                        rise_q <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    if (!s) begin
                        state  <= WAIT_LOW;
                        cnt    <= CNT_ONE;
                        busy_q <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (s) begin
                        state  <= HIGH;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= LOW;
                        cnt    <= '0;
                        o_q    <= 1'b0;
                        busy_q <= 1'b0;
`ifdef DEBOUNCE_EDGE_PULSE_EN
                        fall_q <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state  <= LOW;
                    cnt    <= '0;
                    o_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o     = o_q;
    assign bus.busy  = busy_q;
    assign fsm_state = state;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
`else
    assign bus.rise  = 1'b0;
    assign bus.fall  = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (STABLE=10, CNT_W=4, 10-unit clock).
// Expected pulse values follow whether DEBOUNCE_EDGE_PULSE_EN is defined for this build.
module tb_input_debouncer;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] fsm_state;
    int         n_cmp = 0;
    int         n_err = 0;

    input_debouncer_if bus();

    input_debouncer #(.STABLE(10), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int e, input bit o_e, input bit busy_e,
                              input bit rise_e, input bit fall_e);
        check($sformatf("%s_o_e%0d", tag, e), {31'd0, bus.o}, {31'd0, o_e});
        check($sformatf("%s_busy_e%0d", tag, e), {31'd0, bus.busy}, {31'd0, busy_e});
        check($sformatf("%s_rise_e%0d", tag, e), {31'd0, bus.rise}, {31'd0, rise_e});
        check($sformatf("%s_fall_e%0d", tag, e), {31'd0, bus.fall}, {31'd0, fall_e});
    endtask

    initial begin
        bus.i = 1'b0;
        #1;
        check_outs("reset_async", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_state", {30'd0, fsm_state}, 32'd0);

        // Reset held for 3 cycles, then idle low for 20 cycles.
        for (int c = 0; c < 3; c++) begin
            tick();
            check_outs("reset_hold", c, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_outs("idle", c, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Clean rise: o, rise on edge 11; busy over edges 2..10.
        bus.i = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            tick();
            check_outs("rise", e, e >= 11, (e >= 2 && e <= 10), PE && (e == 11), 1'b0);
        end
        check("rise_state", {30'd0, fsm_state}, 32'd2);

        // Clean fall.
        bus.i = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            tick();
            check_outs("fall", e, e < 11, (e >= 2 && e <= 10), 1'b0, PE && (e == 11));
        end
        check("fall_state", {30'd0, fsm_state}, 32'd0);

        // Glitch of 5 cycles: WAIT entered at edge 2, dropped at edge 7.
        bus.i = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            tick();
            if (e == 4) bus.i = 1'b0;
            check_outs("glitch5", e, 1'b0, (e >= 2 && e <= 6), 1'b0, 1'b0);
        end

        // 9 sampled cycles: one short of STABLE, rejected at edge 11.
        bus.i = 1'b1;
        for (int e = 0; e <= 13; e++) begin
            tick();
            if (e == 8) bus.i = 1'b0;
            check_outs("glitch9", e, 1'b0, (e >= 2 && e <= 10), 1'b0, 1'b0);
        end

        // Exactly 10 sampled cycles: accepted at edge 11, then falls back at edge 21.
        bus.i = 1'b1;
        for (int e = 0; e <= 22; e++) begin
            tick();
            if (e == 9) bus.i = 1'b0;
            check_outs("exact10", e, (e >= 11 && e <= 20),
                       (e >= 2 && e <= 10) || (e >= 12 && e <= 20),
                       PE && (e == 11), PE && (e == 21));
        end

        // Reset mid-qualification, asserted between edges.
        bus.i = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            tick();
        end
        check_outs("pre_rst", 6, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_cnt", {28'd0, dut.cnt}, 32'd5);
        #4;
        rst = 1'b1;
        #1;
        check_outs("mid_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_rst_cnt", {28'd0, dut.cnt}, 32'd0);
        check("mid_rst_state", {30'd0, fsm_state}, 32'd0);
        check("mid_rst_s1", {31'd0, dut.s1}, 32'd0);
        check("mid_rst_s", {31'd0, dut.s}, 32'd0);
        tick();
        tick();
        check_outs("rst_held", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e <= 12; e++) begin
            tick();
            check_outs("post_rst", e, e >= 11, (e >= 2 && e <= 10), PE && (e == 11), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
